// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported memory with combinational read data.
// Each transaction runs IDLE -> ACCESS -> RESP, so one transaction can start every three cycles.
module mem_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          cpu_stall,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   grant;
    logic   pick;

    // On a tie the port that did not win last time goes next; a lone request always wins.
    always_comb begin
        pick = 1'b0;
        if (p0_req && p1_req) begin
            pick = ~last_grant;
        end else if (p1_req) begin
            pick = 1'b1;
        end
    end

    // mem_we doubles as the latched access type: it is only ever high during ACCESS.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    p0_ack <= 1'b0;
                    p1_ack <= 1'b0;
                    if (p0_req || p1_req) begin
                        grant      <= pick;
                        last_grant <= pick;
                        mem_en     <= 1'b1;
                        mem_we     <= pick ? p1_we    : p0_we;
                        mem_addr   <= pick ? p1_addr  : p0_addr;
                        mem_wdata  <= pick ? p1_wdata : p0_wdata;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (!mem_we) begin
                        if (grant) begin
                            p1_rdata <= mem_rdata;
                        end else begin
                            p0_rdata <= mem_rdata;
                        end
                    end
                    p0_ack <= ~grant;
                    p1_ack <= grant;
                    state  <= RESP;
                end
                RESP: begin
                    p0_ack <= 1'b0;
                    p1_ack <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    p0_ack <= 1'b0;
                    p1_ack <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign cpu_stall = p0_req & ~p0_ack;

    a_ack_exclusive: assert property (@(posedge clk) !(p0_ack && p1_ack));
    a_we_needs_en:   assert property (@(posedge clk) mem_we |-> mem_en);

endmodule
